i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- I2C target (responder) that presents an 8-bit register space at a 7-bit device address.
- Models the register side of an MPU-9150-class sensor so the existing I2C master and its sensor-read FSM can be exercised on-chip and in simulation without the real part.
- Oversamples SCL/SDA on the system clock; supports standard single-byte pointer write, burst write, and burst read with repeated start.
- Register storage is external, behind a simple synchronous read/write strobe port.

Parameters:
- DEV_ADDR, 7'h68: 7-bit device address this target responds to.
- SYNC_STAGES, 2: synchronizer flops on SCL and SDA inputs (min 2).

Ports:
- clk  input  1  system clock, 50 MHz; SCL up to 400 kHz.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock from master; never driven; no clock stretching.
- sda  inout  1  I2C data, open-drain: driven 0 or left 'z'.
- reg_addr  output  8  register pointer for current access.
- reg_wdata  output  8  write data, valid with reg_we.
- reg_we  output  1  one-cycle write strobe.
- reg_rd  output  1  one-cycle read request.
- reg_rdata  input  8  read data; must be valid the cycle after reg_rd.
- busy  output  1  high from an address match until STOP or the next START.

Behaviour:
- Reset values: sda released ('z'), reg_addr 0, reg_wdata 0, reg_we 0, reg_rd 0, busy 0, state IDLE. Reset mid-transfer releases SDA immediately; the block then waits for the next START.
- Line conditioning:
  - SCL and SDA pass through SYNC_STAGES flops, then edge detection on the synchronized values.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - SDA is sampled on SCL rising edges. The block changes its SDA drive only on the cycle after an SCL falling edge.
- START and STOP are honoured in every state and take priority over bit processing:
  - START (including repeated start) → ADDR, bit counter cleared, SDA released.
  - STOP → IDLE, busy 0, SDA released.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
  - ADDR: shift 8 bits MSB first. On the 8th rising edge, compare bits[7:1] with DEV_ADDR.
    - Mismatch → IGNORE (SDA never driven; wait for START or STOP).
    - Match → busy 1, ADDR_ACK.
    - Match with R/W=1 also pulses reg_rd with reg_addr = current pointer; the transmit shifter loads reg_rdata one cycle later.
  - ADDR_ACK: drive SDA low from the 8th falling edge until the 9th falling edge. Then go to RD if R/W=1, or to PTR if R/W=0.
  - PTR: 8 bits received. On the 8th rising edge, load reg_addr with the byte, then ACK (PTR_ACK) → WR.
  - WR: 8 bits received. On the 8th rising edge, reg_wdata ← byte and pulse reg_we for one cycle with the current reg_addr. Then ACK (WR_ACK) → WR.
    - reg_addr increments by 1 one cycle after reg_we; 8'hFF wraps to 8'h00.
  - RD: drive bit 7 of the shifter after the ACK falling edge, then shift on each falling edge. Drive 0 as low, 1 as release. After the 8th falling edge, release SDA → RD_ACK.
  - RD_ACK: sample master ACK on the 9th rising edge.
    - ACK (0): reg_addr++, pulse reg_rd, load shifter with the new reg_rdata → RD.
    - NACK (1): → IGNORE.
- Pointer persistence: the pointer survives repeated START and STOP, so write-pointer, Sr, read-burst works. The pointer is cleared only by reset.
- Bit counter is 4 bits, 0–8; it counts rising edges within a byte.
- Write to a read-only location is still strobed; the external register bank decides whether to store it.
- Latency: reg_we is asserted 1 + SYNC_STAGES clk after the 8th SCL rising edge at the pin.

Optional Feature:
- Macro: I2C_SLV_GLITCH_FILTER_EN.
- Defined: after synchronization, SCL and SDA each pass a 3-sample stable filter. The filtered value changes only after 3 consecutive equal samples, which rejects spikes of 2 clk (40 ns) or less and adds 2 clk of latency.
- Undefined: the synchronized values are used directly.

Decomposition:
- Package i2c_pkg: FSM state encodings, I2C_ACK/I2C_NACK constants, MPU9150_ADDR = 7'h68. The package is shared with the master-side FSM.
- Sub-module i2c_line_sync: synchronizer, optional filter, and rise/fall/level outputs. Instantiated once for SCL and once for SDA.
- START/STOP detection stays in the top level because it needs both lines.

Test Plan:
- Write 0x68+W, ptr 0x3B, data 0xA5, 0x5A, STOP → reg_we pulses with (0x3B, 0xA5) then (0x3C, 0x5A); all three bytes ACKed; busy 0 after STOP.
- Write 0x68+W, ptr 0x3B, Sr, 0x68+R, read 2 bytes (ACK, then NACK) with bank 0x3B=0x12, 0x3C=0x34 → master receives 0x12, 0x34; reg_rd pulses with 0x3B then 0x3C; SDA released after the NACK.
- Address 0x69+W → no ACK (SDA reads 1 on the 9th clock); no reg_we or reg_rd; busy stays 0.
- Burst write starting at ptr 0xFF, 2 data bytes → writes to 0xFF then 0x00.
- STOP after 4 bits of a data byte → no reg_we; state IDLE; next transaction is ACKed normally.
- rst_n low while driving ACK → sda 'z' within the reset assertion; all outputs at reset values; next START is handled normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NACK levels, sensor address,
// and the per-line event bundle produced by the line conditioner.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_PTR      = 4'd3;
  localparam logic [3:0] ST_PTR_ACK  = 4'd4;
  localparam logic [3:0] ST_WR       = 4'd5;
  localparam logic [3:0] ST_WR_ACK   = 4'd6;
  localparam logic [3:0] ST_RD       = 4'd7;
  localparam logic [3:0] ST_RD_ACK   = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] MPU9150_ADDR = 7'h68;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } line_t;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer plus edge detector for one I2C line (SCL or SDA).
// Optional 3-sample stable filter enabled by I2C_SLV_GLITCH_FILTER_EN.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_line,
  output line_t o_line
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_level;
  logic                   r_prev;

  // Flops reset to 1 so an idle (pulled-up) bus produces no edge at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_hold;
  logic       w_stable;

  // Output follows only when the current and two previous samples agree.
  assign w_stable = (w_sync == r_hist[0]) && (r_hist[0] == r_hist[1]);
  assign w_level  = w_stable ? w_sync : r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 2'b11;
      r_hold <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], w_sync};
      r_hold <= w_level;
    end
  end
`else
  assign w_level = w_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_line.level = w_level;
  assign o_line.rise  = w_level & ~r_prev;
  assign o_line.fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit register space through a strobe port.
// Build option: I2C_SLV_GLITCH_FILTER_EN adds a spike filter on SCL/SDA.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = MPU9150_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  line_t      w_scl;
  line_t      w_sda;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_last_bit;

  logic [3:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic       r_rw;
  logic       r_ack_drv;
  logic       r_mack;
  logic       r_sda_low;
  logic       r_rd_load;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic       r_reg_we;
  logic       r_reg_rd;
  logic       r_busy;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (scl),
    .o_line (w_scl)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (sda),
    .o_line (w_sda)
  );

  assign w_start    = w_sda.fall & w_scl.level;
  assign w_stop     = w_sda.rise & w_scl.level;
  assign w_byte     = {r_rx, w_sda.level};
  assign w_last_bit = (r_bit_cnt == 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 4'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_rw        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_mack      <= 1'b0;
      r_sda_low   <= 1'b0;
      r_rd_load   <= 1'b0;
      r_reg_addr  <= 8'd0;
      r_reg_wdata <= 8'd0;
      r_reg_we    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_reg_we  <= 1'b0;
      r_reg_rd  <= 1'b0;
      r_rd_load <= r_reg_rd;
      // Read data arrives the cycle after the request; capture it then.
      if (r_rd_load) begin
        r_tx <= reg_rdata;
      end
      if (r_reg_we) begin
        r_reg_addr <= r_reg_addr + 8'd1;
      end

      if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
        r_ack_drv <= 1'b0;
        r_mack    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
        r_ack_drv <= 1'b0;
        r_mack    <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WR: begin
            if (w_scl.rise) begin
              r_rx      <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                case (r_state)
                  ST_ADDR: begin
                    if (addr_match(w_byte, DEV_ADDR)) begin
                      r_busy   <= 1'b1;
                      r_rw     <= w_byte[0];
                      r_reg_rd <= w_byte[0];
                      r_state  <= ST_ADDR_ACK;
                    end else begin
                      r_state <= ST_IGNORE;
                    end
                  end
                  ST_PTR: begin
                    r_reg_addr <= w_byte;
                    r_state    <= ST_PTR_ACK;
                  end
                  default: begin
                    r_reg_wdata <= w_byte;
                    r_reg_we    <= 1'b1;
                    r_state     <= ST_WR_ACK;
                  end
                endcase
              end
            end
          end

          // First falling edge starts the ACK pulse, the second ends it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
            if (w_scl.fall) begin
              if (!r_ack_drv) begin
                r_ack_drv <= 1'b1;
                r_sda_low <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 4'd0;
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  r_state   <= ST_RD;
                  r_sda_low <= ~r_tx[7];
                end else begin
                  r_state   <= (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WR;
                  r_sda_low <= 1'b0;
                end
              end
            end
          end

          ST_RD: begin
            if (w_scl.rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_scl.fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_low <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= ST_RD_ACK;
              end else begin
                r_tx      <= {r_tx[6:0], 1'b0};
                r_sda_low <= ~r_tx[6];
              end
            end
          end

          ST_RD_ACK: begin
            if (w_scl.rise) begin
              if (w_sda.level == I2C_ACK) begin
                r_mack     <= 1'b1;
                r_reg_addr <= r_reg_addr + 8'd1;
                r_reg_rd   <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end else if (w_scl.fall && r_mack) begin
              r_mack    <= 1'b0;
              r_state   <= ST_RD;
              r_sda_low <= ~r_tx[7];
            end
          end

          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_we    = r_reg_we;
  assign reg_rd    = r_reg_rd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: bit-banged I2C master, register bank model, and a
// scoreboard of expected register strobes compared against observed ones.
module tb_i2c_slave_regs;

  localparam int Q = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  logic       pre_en = 1'b0;
  logic [7:0] pre_a = 8'd0;
  logic [7:0] pre_d = 8'd0;
  logic [7:0] bank [256];

  int errors = 0;
  int checks = 0;

  wr_t        exp_wr[$];
  wr_t        obs_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] obs_rd[$];

  always #10 clk = ~clk;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(.DEV_ADDR(7'h68), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register bank: read data valid the cycle after reg_rd.
  always @(posedge clk) begin
    if (pre_en) bank[pre_a] <= pre_d;
    if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
      obs_wr.push_back({reg_addr, reg_wdata});
    end
    if (reg_rd) begin
      reg_rdata <= bank[reg_addr];
      obs_rd.push_back(reg_addr);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    wr_t        we_e, we_o;
    logic [7:0] rd_e, rd_o;
    check({tag, " we count"}, obs_wr.size(), exp_wr.size());
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      we_e = exp_wr.pop_front();
      we_o = obs_wr.pop_front();
      check({tag, " we addr/data"}, {16'd0, we_o}, {16'd0, we_e});
    end
    check({tag, " rd count"}, obs_rd.size(), exp_rd.size());
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_e = exp_rd.pop_front();
      rd_o = obs_rd.pop_front();
      check({tag, " rd addr"}, {24'd0, rd_o}, {24'd0, rd_e});
    end
    exp_wr.delete();
    obs_wr.delete();
    exp_rd.delete();
    obs_rd.delete();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    clks(1);
    pre_en = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    m_sda_low = 1'b1;
    clks(Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    m_sda_low = 1'b0;
    clks(2 * Q);
  endtask

  task automatic wbit(input logic b);
    m_sda_low = ~b;
    clks(Q);
    scl = 1'b1;
    clks(2 * Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic rbit(output logic b);
    m_sda_low = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    b = sda;
    clks(Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(mack);
    m_sda_low = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;

    // Reset values
    clks(5);
    check("reset reg_addr", {24'd0, reg_addr}, 32'h00);
    check("reset reg_wdata", {24'd0, reg_wdata}, 32'h00);
    check("reset reg_we", {31'd0, reg_we}, 32'h0);
    check("reset reg_rd", {31'd0, reg_rd}, 32'h0);
    check("reset busy", {31'd0, busy}, 32'h0);
    check("reset sda", {31'd0, sda}, 32'h1);
    rst_n = 1'b1;
    clks(10);

    // Burst write 0x3B: A5, 5A
    i2c_start();
    wbyte(8'hD0, ack); check("t1 addr ack", {31'd0, ack}, 32'h0);
    wbyte(8'h3B, ack); check("t1 ptr ack", {31'd0, ack}, 32'h0);
    exp_wr.push_back({8'h3B, 8'hA5});
    wbyte(8'hA5, ack); check("t1 d0 ack", {31'd0, ack}, 32'h0);
    exp_wr.push_back({8'h3C, 8'h5A});
    wbyte(8'h5A, ack); check("t1 d1 ack", {31'd0, ack}, 32'h0);
    check("t1 busy active", {31'd0, busy}, 32'h1);
    i2c_stop();
    check("t1 busy after stop", {31'd0, busy}, 32'h0);
    check("t1 ptr", {24'd0, reg_addr}, 32'h3D);
    drain("t1");
    $display("txn t1: burst write 0x3B done");

    // Pointer write, repeated start, 2-byte read
    preload(8'h3B, 8'h12);
    preload(8'h3C, 8'h34);
    i2c_start();
    wbyte(8'hD0, ack); check("t2 addr ack", {31'd0, ack}, 32'h0);
    wbyte(8'h3B, ack); check("t2 ptr ack", {31'd0, ack}, 32'h0);
    i2c_start();
    exp_rd.push_back(8'h3B);
    wbyte(8'hD1, ack); check("t2 raddr ack", {31'd0, ack}, 32'h0);
    exp_rd.push_back(8'h3C);
    rbyte(1'b0, rd); check("t2 rd byte0", {24'd0, rd}, 32'h12);
    rbyte(1'b1, rd); check("t2 rd byte1", {24'd0, rd}, 32'h34);
    clks(2);
    check("t2 sda released", {31'd0, sda}, 32'h1);
    i2c_stop();
    check("t2 ptr", {24'd0, reg_addr}, 32'h3C);
    drain("t2");
    $display("txn t2: read 0x3B..0x3C done");

    // Wrong address
    i2c_start();
    wbyte(8'hD2, ack); check("t3 addr nack", {31'd0, ack}, 32'h1);
    check("t3 busy", {31'd0, busy}, 32'h0);
    wbyte(8'h55, ack); check("t3 data nack", {31'd0, ack}, 32'h1);
    i2c_stop();
    drain("t3");
    $display("txn t3: foreign address ignored");

    // Pointer wrap 0xFF -> 0x00
    i2c_start();
    wbyte(8'hD0, ack); check("t4 addr ack", {31'd0, ack}, 32'h0);
    wbyte(8'hFF, ack); check("t4 ptr ack", {31'd0, ack}, 32'h0);
    exp_wr.push_back({8'hFF, 8'h11});
    wbyte(8'h11, ack); check("t4 d0 ack", {31'd0, ack}, 32'h0);
    exp_wr.push_back({8'h00, 8'h22});
    wbyte(8'h22, ack); check("t4 d1 ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    check("t4 ptr", {24'd0, reg_addr}, 32'h01);
    drain("t4");
    $display("txn t4: wrap write done");

    // STOP after 4 data bits, then normal write
    i2c_start();
    wbyte(8'hD0, ack); check("t5 addr ack", {31'd0, ack}, 32'h0);
    wbyte(8'h40, ack); check("t5 ptr ack", {31'd0, ack}, 32'h0);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    i2c_stop();
    check("t5 busy", {31'd0, busy}, 32'h0);
    drain("t5a");
    i2c_start();
    wbyte(8'hD0, ack); check("t5b addr ack", {31'd0, ack}, 32'h0);
    wbyte(8'h41, ack); check("t5b ptr ack", {31'd0, ack}, 32'h0);
    exp_wr.push_back({8'h41, 8'h77});
    wbyte(8'h77, ack); check("t5b d0 ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    drain("t5b");
    $display("txn t5: aborted byte then write done");

    // Reset while the target drives ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(rd_bit_of_d0(i));
    m_sda_low = 1'b0;
    clks(2);
    check("t6 ack driven", {31'd0, sda}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6 sda in reset", {31'd0, sda}, 32'h1);
    check("t6 busy in reset", {31'd0, busy}, 32'h0);
    check("t6 ptr in reset", {24'd0, reg_addr}, 32'h00);
    scl = 1'b1;
    clks(5);
    rst_n = 1'b1;
    clks(10);
    i2c_start();
    wbyte(8'hD0, ack); check("t6b addr ack", {31'd0, ack}, 32'h0);
    wbyte(8'h10, ack); check("t6b ptr ack", {31'd0, ack}, 32'h0);
    exp_wr.push_back({8'h10, 8'h99});
    wbyte(8'h99, ack); check("t6b d0 ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    drain("t6b");
    $display("txn t6: reset mid-ACK recovered");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic rd_bit_of_d0(input int i);
    logic [7:0] v;
    v = 8'hD0;
    return v[i];
  endfunction

endmodule
